// File: rtl/maj_net_sequencer_pkg.sv
// maj_net_pkg: operand select encoding, program word layout and sequencer states
package maj_net_pkg;
  localparam int MAX_GATES = 16;
  localparam int SEL_W = 5;
  localparam int OP_W = 6;
  localparam logic [SEL_W-1:0] SEL_CONST0 = 5'd0;
  localparam logic [SEL_W-1:0] SEL_X0 = 5'd1;
  localparam logic [SEL_W-1:0] SEL_G0 = 5'd8;
  localparam logic [SEL_W-1:0] SEL_RSVD = 5'd24;
  typedef struct packed {
    logic inv;
    logic [SEL_W-1:0] sel;
  } operand_t;
  typedef struct packed {
    operand_t c;
    operand_t b;
    operand_t a;
  } gate_word_t;
  typedef enum logic [1:0] {IDLE, EVAL, EMIT, DONE} state_t;
endpackage

// File: rtl/maj_net_sequencer_if.sv
// maj_net_sequencer_if: result bit stream, one minterm per valid/ready handshake
interface maj_net_sequencer_if;
  logic res_valid;
  logic res_ready;
  logic [6:0] res_idx;
  logic res_bit;
  modport master(output res_valid, res_idx, res_bit, input res_ready);
  modport slave(input res_valid, res_idx, res_bit, output res_ready);
endinterface

// File: rtl/maj_net_sequencer_maj3.sv
// maj3_unit: the single shared three-input majority gate
module maj3_unit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_y
);
  assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

// File: rtl/maj_net_sequencer.sv
// maj_net_sequencer: sweeps all 128 minterms through a MIG program, one gate per cycle
module maj_net_sequencer
  import maj_net_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        prog_we,
  input  logic [3:0]                  prog_addr,
  input  logic [17:0]                 prog_data,
  input  logic [4:0]                  num_gates,
  input  logic [4:0]                  out_sel,
  input  logic                        out_inv,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  maj_net_sequencer_if.master         res,
  output logic [127:0]                tt
);
  state_t r_state;
  gate_word_t r_prog [MAX_GATES];
  logic [4:0] r_num, r_out_sel;
  logic r_out_inv, r_err;
  logic [3:0] r_gi;
  logic [6:0] r_m;
  logic [15:0] r_g;
  logic [127:0] r_tt;
  gate_word_t w_gw;
  logic [1:0] w_a, w_b, w_c, w_o;
  logic w_maj;
  logic [4:0] w_num;
  // returns {illegal, value}; g_j is legal only below lim, and illegal reads yield 0
  function automatic logic [1:0] fetch(operand_t op, logic [4:0] lim, logic [6:0] m, logic [15:0] g);
    logic [4:0] d;
    logic [7:0] xs;
    logic ill, src;
    d = op.sel - SEL_G0;
    xs = {m, 1'b0};
    ill = op.sel >= SEL_RSVD || (op.sel >= SEL_G0 && d >= lim);
    src = op.sel < SEL_G0 ? xs[op.sel[2:0]] : g[d[3:0]];
    return {ill, ill ? 1'b0 : op.inv ^ src};
  endfunction
  assign w_num = num_gates > 5'(MAX_GATES) ? 5'(MAX_GATES) : num_gates;
  assign w_gw = r_prog[r_gi];
  assign w_a = fetch(w_gw.a, {1'b0, r_gi}, r_m, r_g);
  assign w_b = fetch(w_gw.b, {1'b0, r_gi}, r_m, r_g);
  assign w_c = fetch(w_gw.c, {1'b0, r_gi}, r_m, r_g);
  assign w_o = fetch({r_out_inv, r_out_sel}, r_num, r_m, r_g);
  maj3_unit u_maj (.i_a(w_a[0]), .i_b(w_b[0]), .i_c(w_c[0]), .o_y(w_maj));
  assign busy = r_state == EVAL || r_state == EMIT;
  assign done = r_state == DONE;
  assign err = r_err;
  assign tt = r_tt;
  assign res.res_valid = r_state == EMIT;
  assign res.res_idx = r_m;
  assign res.res_bit = r_state == EMIT && w_o[0];
  always_ff @(posedge clk) begin
    if (prog_we && r_state == IDLE) r_prog[prog_addr] <= gate_word_t'(prog_data);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_num <= '0;
      r_out_sel <= '0;
      r_out_inv <= 1'b0;
      r_err <= 1'b0;
      r_gi <= '0;
      r_m <= '0;
      r_g <= '0;
      r_tt <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_num <= w_num;
          r_out_sel <= out_sel;
          r_out_inv <= out_inv;
          r_err <= 1'b0;
          r_m <= '0;
          r_gi <= '0;
          r_state <= w_num == 5'd0 ? EMIT : EVAL;
        end
        EVAL: begin
          r_g[r_gi] <= w_maj;
          r_err <= r_err | w_a[1] | w_b[1] | w_c[1];
          r_gi <= r_gi + 4'd1;
          if ({1'b0, r_gi} == r_num - 5'd1) r_state <= EMIT;
        end
        EMIT: begin
          r_err <= r_err | w_o[1];
          if (res.res_ready) begin
            r_tt[r_m] <= w_o[0];
            r_m <= r_m + 7'd1;
            r_gi <= '0;
            r_state <= r_m == 7'd127 ? DONE : r_num == 5'd0 ? EMIT : EVAL;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maj_net_sequencer.sv
// tb_maj_net_sequencer: directed sweeps with a scoreboard of expected result bits
module tb_maj_net_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, prog_we = 1'b0, out_inv = 1'b0, start = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [17:0] prog_data = '0;
  logic [4:0] num_gates = '0, out_sel = '0;
  logic busy, done, err;
  logic [127:0] tt;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [17:0] bp [16];
  logic [7:0] q [$];
  localparam logic [127:0] TT7 = 128'hfeeeeeeafae8ea80fea8e8a0a8888880;
  maj_net_sequencer_if rif ();
  always #5 clk = ~clk;
  maj_net_sequencer dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .num_gates(num_gates), .out_sel(out_sel), .out_inv(out_inv), .start(start),
    .busy(busy), .done(done), .err(err), .res(rif), .tt(tt)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask
  function automatic logic [17:0] gw(input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
    return {c, b, a};
  endfunction
  function automatic logic opv(input logic [5:0] op, input int lim, input logic [6:0] m, input logic [15:0] g);
    int s = int'(op[4:0]);
    if (s == 0) return op[5];
    if (s < 8) return op[5] ^ m[s-1];
    if (s < 24 && s - 8 < lim) return op[5] ^ g[s-8];
    return 1'b0;
  endfunction
  function automatic logic mbit(input int n, input logic [4:0] os, input logic oi, input logic [6:0] m);
    logic [15:0] g = '0;
    logic [17:0] w;
    logic a, b, c;
    for (int k = 0; k < n; k++) begin
      w = bp[k];
      a = opv(w[5:0], k, m, g);
      b = opv(w[11:6], k, m, g);
      c = opv(w[17:12], k, m, g);
      g[k] = (a & b) | (a & c) | (b & c);
    end
    return opv({oi, os}, n, m, g);
  endfunction
  task automatic wr(input int a, input logic [17:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    bp[a] = d;
  endtask
  task automatic load7();
    wr(0, gw(1, 5, 6)); wr(1, gw(1, 2, 6)); wr(2, gw(2, 4, 5)); wr(3, gw(3, 9, 10));
    wr(4, gw(3, 8, 9)); wr(5, gw(1, 4, 12)); wr(6, gw(7, 11, 13));
  endtask
  task automatic kick(input int n, input logic [4:0] os, input logic oi);
    logic [6:0] m;
    q.delete();
    for (int i = 0; i < 128; i++) begin
      m = 7'(i);
      q.push_back({m, mbit(n, os, oi, m)});
    end
    @(negedge clk);
    num_gates = 5'(n); out_sel = os; out_inv = oi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
  endtask
  task automatic finish_run(input int stall_at);
    logic stalled = 1'b0;
    logic [7:0] sv;
    while (!done && cyc < 5000) begin
      if (stall_at >= 0 && !stalled && rif.res_valid && rif.res_idx == 7'(stall_at)) begin
        stalled = 1'b1;
        rif.res_ready = 1'b0;
        sv = {rif.res_idx, rif.res_bit};
        repeat (5) begin
          @(negedge clk);
          cyc++;
          chk("stall_hold", {rif.res_valid, rif.res_idx, rif.res_bit}, {1'b1, sv});
        end
        rif.res_ready = 1'b1;
      end
      if (rif.res_valid && rif.res_ready)
        chk("sb_result", {1'b1, rif.res_idx, rif.res_bit}, q.size() != 0 ? {1'b1, q.pop_front()} : 9'h0);
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", done, 1'b1);
    chk("sb_drained", q.size(), 0);
  endtask
  initial begin
    rif.res_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {busy, done, err, rif.res_valid, rif.res_idx, rif.res_bit}, '0);
    chk("rst_tt", tt, '0);
    rst_n = 1'b1;
    wr(0, gw(1, 2, 3));
    kick(1, 5'd8, 1'b0);
    finish_run(-1);
    chk("g0_cycles", cyc, 257);
    chk("g0_tt", tt, {16{8'hE8}});
    chk("g0_err", err, 1'b0);
    kick(0, 5'd7, 1'b0);
    finish_run(-1);
    chk("x6_cycles", cyc, 129);
    chk("x6_tt", tt, {64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    kick(0, 5'd1, 1'b1);
    finish_run(-1);
    chk("nx0_cycles", cyc, 129);
    chk("nx0_tt", tt, {32{4'h5}});
    chk("nx0_err", err, 1'b0);
    load7();
    kick(7, 5'd14, 1'b0);
    finish_run(-1);
    chk("mig7_cycles", cyc, 1025);
    chk("mig7_tt", tt, TT7);
    chk("mig7_err", err, 1'b0);
    kick(0, 5'd1, 1'b1);
    finish_run(-1);
    kick(7, 5'd14, 1'b0);
    finish_run(10);
    chk("stall_cycles", cyc, 1030);
    chk("stall_tt", tt, TT7);
    wr(0, gw(9, 2, 3));
    wr(1, gw(1, 2, 3));
    kick(2, 5'd9, 1'b0);
    while (!rif.res_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("err_first_emit", err, 1'b1);
    rif.res_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = gw(1, 2, 3);
    @(negedge clk);
    cyc++;
    prog_we = 1'b0;
    rif.res_ready = 1'b1;
    finish_run(-1);
    chk("err_at_done", err, 1'b1);
    kick(2, 5'd9, 1'b0);
    chk("err_cleared", err, 1'b0);
    finish_run(-1);
    chk("err_prog_kept", err, 1'b1);
    load7();
    kick(7, 5'd14, 1'b0);
    while (!(rif.res_valid && rif.res_idx == 7'd40) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_m40", {rif.res_valid, rif.res_idx}, {1'b1, 7'd40});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {busy, done, err, rif.res_valid, rif.res_idx, rif.res_bit}, '0);
    chk("async_rst_tt", tt, '0);
    @(negedge clk);
    rst_n = 1'b1;
    kick(7, 5'd14, 1'b0);
    finish_run(-1);
    chk("post_rst_tt", tt, TT7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
